// File: rtl/shift_add_mult_ctrl.sv
// Sequential 8x8 unsigned shift-add multiplier, paced by an external 8-step counter.
// Optional: define MULT_TIMEOUT_EN to add a 16-cycle RUN watchdog that pulses err.
module shift_add_mult_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        cnt_start,
    input  logic        cnt_done,
    output logic        busy,
    output logic        valid,
    output logic [15:0] product,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [16:0] acc_q, acc_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] product_q, product_d;
    logic [8:0]  sum;

`ifdef MULT_TIMEOUT_EN
    logic [3:0]  wdog_q, wdog_d;
    logic        err_q, err_d;
`endif

    // acc_q = {carry, partial product high byte, remaining multiplier bits}
    assign sum = acc_q[16:8] + {1'b0, mcand_q};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        step_d    = step_q;
        product_d = product_q;
`ifdef MULT_TIMEOUT_EN
        wdog_d    = wdog_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    mcand_d = a;
                    acc_d   = {9'd0, b};
                    step_d  = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                state_d = RUN;
`ifdef MULT_TIMEOUT_EN
                wdog_d  = 4'd0;
`endif
            end
            RUN: begin
                if (cnt_done) begin
                    product_d = acc_q[15:0];
                    state_d   = DONE;
                end else begin
                    if (step_q < 4'd8) begin
                        acc_d  = acc_q[0] ? {1'b0, sum, acc_q[7:1]} : {1'b0, acc_q[16:1]};
                        step_d = step_q + 4'd1;
                    end
`ifdef MULT_TIMEOUT_EN
                    if (wdog_q == 4'hF) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wdog_d  = wdog_q + 4'd1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 8'd0;
            acc_q     <= 17'd0;
            step_q    <= 4'd0;
            product_q <= 16'd0;
`ifdef MULT_TIMEOUT_EN
            wdog_q    <= 4'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            product_q <= product_d;
`ifdef MULT_TIMEOUT_EN
            wdog_q    <= wdog_d;
            err_q     <= err_d;
`endif
        end
    end

    assign cnt_start = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign valid     = (state_q == DONE);
    assign product   = product_q;
`ifdef MULT_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: vector table + scoreboard, with a model 8-step counter.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        cnt_start;
    logic        cnt_done;
    logic        busy;
    logic        valid;
    logic [15:0] product;
    logic        err;

    shift_add_mult_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
        .cnt_start(cnt_start), .cnt_done(cnt_done), .busy(busy),
        .valid(valid), .product(product), .err(err)
    );

    always #5 clk = ~clk;

    // Counter model: done rises 8 edges after the edge that samples cnt_start.
    logic       c_run = 1'b0;
    logic [3:0] c_cnt = 4'd0;
    logic       hold_done = 1'b0;
    always @(posedge clk) begin
        if (cnt_start === 1'b1) begin
            c_run <= 1'b1;
            c_cnt <= 4'd8;
        end else if (c_run) begin
            if (c_cnt == 4'd0) c_run <= 1'b0;
            else               c_cnt <= c_cnt - 4'd1;
        end
    end
    assign cnt_done = c_run && (c_cnt == 4'd0) && !hold_done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_prod = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard side: every valid pulse pops one expected product.
    always @(negedge clk) begin
        if (cnt_start === 1'b1) start_cnt++;
        if (err === 1'b1) err_cnt++;
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else check("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
        end
    end

    // Called just after an accepting edge; returns edges to valid, or -1 on timeout.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (valid === 1'b1) return;
        end
        edges = -1;
    endtask

    task automatic do_mult(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp);
        int edges;
        int s0;
        @(negedge clk);
        check("product_held", {16'd0, product}, {16'd0, last_prod});
        req = 1'b1; a = ia; b = ib;
        exp_q.push_back(exp);
        s0 = start_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_valid(edges);
        check("latency", edges, 10);
        check("start_pulses", start_cnt - s0, 1);
        @(negedge clk);
        check("valid_one_cycle", {31'd0, valid}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        last_prod = exp;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int edges;
        logic [7:0] ra, rb;
        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd1,   8'd255, 16'h00FF};
        vecs[4] = '{8'd128, 8'd2,   16'h0100};
        vecs[5] = '{8'd170, 8'd85,  16'h3872};

        // Asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_start", {31'd0, cnt_start}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 6; i++) do_mult(vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_mult(ra, rb, 16'({8'd0, ra} * {8'd0, rb}));
        end

        // Busy rejection: req held throughout, operands change after acceptance
        @(negedge clk);
        req = 1'b1; a = 8'd13; b = 8'd11;
        exp_q.push_back(16'h008F);
        @(posedge clk);
        #1 a = 8'd2; b = 8'd3;
        wait_valid(edges);
        check("busy_rej_latency", edges, 10);
        exp_q.push_back(16'h0006);
        @(posedge clk);
        #1 check("busy_rej_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 req = 1'b0;
        check("busy_rej_reaccept", {31'd0, busy}, 32'd1);
        wait_valid(edges);
        check("busy_rej_latency2", edges, 10);
        @(negedge clk);
        last_prod = 16'h0006;

        // Abort in the 5th RUN cycle
        do_mult(8'd255, 8'd255, 16'hFE01);
        @(negedge clk);
        req = 1'b1; a = 8'd5; b = 8'd5;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_product", {16'd0, product}, 32'd0);
        @(negedge clk) rst = 1'b0;
        last_prod = 16'h0000;
        repeat (12) @(negedge clk);
        check("abort_no_valid", exp_q.size(), 0);
        do_mult(8'd7, 8'd9, 16'h003F);

        // Counter never reports done
        hold_done = 1'b1;
        @(negedge clk);
        req = 1'b1; a = 8'd3; b = 8'd3;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (30) @(negedge clk);
`ifdef MULT_TIMEOUT_EN
        check("timeout_err_pulses", err_cnt, 1);
        check("timeout_idle", {31'd0, busy}, 32'd0);
        check("timeout_product", {16'd0, product}, {16'd0, last_prod});
`else
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
        check("no_timeout_err", err_cnt, 0);
`endif
        hold_done = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        last_prod = 16'h0000;
        do_mult(8'd6, 8'd7, 16'h002A);

        check("scoreboard_empty", exp_q.size(), 0);
`ifndef MULT_TIMEOUT_EN
        check("err_never", err_cnt, 0);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
